// File: rtl/ber_counter_pkg.sv
// Shared definitions for the PRBS-15 bit-error-rate counter.
// The transmitter-side PRBS source uses the same polynomial and bit order,
// so the taps and shift helpers live here rather than inside the checker.
package ber_counter_pkg;

  // Receiver synchroniser states.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } ber_state_t;

  // PRBS-15, x^15 + x^14 + 1. State s[14:0], newest bit in s[0].
  localparam int PRBS15_WIDTH  = 15;
  localparam int PRBS15_TAP_HI = 14;
  localparam int PRBS15_TAP_LO = 13;

  typedef logic [PRBS15_WIDTH-1:0] prbs15_t;

  localparam prbs15_t PRBS15_ZERO = 15'h0000;

  // Consecutive clean bits needed in VERIFY before declaring lock.
  localparam int VERIFY_LEN_DEFAULT = 32;

  // Next bit the sequence will produce from the given state.
  function automatic logic prbs15_expected(input prbs15_t s);
    return s[PRBS15_TAP_HI] ^ s[PRBS15_TAP_LO];
  endfunction

  // Shift one bit into the state; oldest bit falls off the top.
  function automatic prbs15_t prbs15_shift(input prbs15_t s, input logic b);
    return {s[PRBS15_WIDTH-2:0], b};
  endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// Local PRBS-15 reference for the BER counter.
// In load mode the received bits are shifted straight in so the register
// can be seeded from the line; in free-run mode it regenerates the sequence
// from its own taps, so a line error never contaminates the reference.
module prbs15_lfsr
  import ber_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  input  logic din,
  output logic expected,
  output logic load_nonzero
);

  prbs15_t state;
  prbs15_t state_next;

  // Select between seeding from the line and free-running on own taps.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = prbs15_shift(state, din);
    end else begin
      state_next = prbs15_shift(state, expected);
    end
  end

  // State register; advances only on enabled symbol strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PRBS15_ZERO;
    end else if (en) begin
      state <= state_next;
    end else begin
      state <= state;
    end
  end

  assign expected     = prbs15_expected(state);
  // A seed that would leave the register all-zero is the LFSR lock-up
  // state and can never track a real PRBS stream.
  assign load_nonzero = (prbs15_shift(state, din) != PRBS15_ZERO);

endmodule

// File: rtl/ber_counter.sv
// PRBS-15 bit-error-rate counter.
// Acquires the incoming PRBS by seeding a local LFSR from the line, verifies
// the alignment over a run of clean bits, then counts errors in fixed
// windows of 2^WINDOW_LOG2 bits. Lock is dropped when a window is too dirty.
module ber_counter
  import ber_counter_pkg::*;
#(
  parameter int WINDOW_LOG2 = 20,
  parameter int VERIFY_LEN  = VERIFY_LEN_DEFAULT,
  parameter int LOSS_THRESH = 2 ** (WINDOW_LOG2 - 3)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sam_clk_en,
  input  logic                   bit_in,
  output logic                   locked,
  output logic [WINDOW_LOG2:0]   err_count,
  output logic                   window_done,
  output logic [7:0]             resync_count
);

  localparam int ACC_W = WINDOW_LOG2 + 1;
  localparam int VCW   = $clog2(VERIFY_LEN + 1);

  localparam logic [3:0]             FILL_LAST    = 4'(PRBS15_WIDTH - 1);
  localparam logic [VCW-1:0]         VERIFY_LAST  = VCW'(VERIFY_LEN - 1);
  localparam logic [WINDOW_LOG2-1:0] BIT_CNT_LAST = {WINDOW_LOG2{1'b1}};
  localparam logic [ACC_W-1:0]       LOSS_LIM     = ACC_W'(LOSS_THRESH);
  localparam logic [7:0]             RESYNC_MAX   = 8'd255;

  ber_state_t             state;
  ber_state_t             state_next;
  logic [3:0]             fill_cnt;
  logic [VCW-1:0]         verify_cnt;
  logic [WINDOW_LOG2-1:0] bit_cnt;
  logic [ACC_W-1:0]       err_acc;
  logic [ACC_W-1:0]       window_total;
  logic                   expected;
  logic                   load_nonzero;
  logic                   bit_err;
  logic                   window_end;
  logic                   window_loss;

  prbs15_lfsr u_lfsr (
    .clk          (clk),
    .reset        (reset),
    .en           (sam_clk_en),
    .load         (state == ST_SEARCH),
    .din          (bit_in),
    .expected     (expected),
    .load_nonzero (load_nonzero)
  );

  assign bit_err      = bit_in ^ expected;
  assign window_end   = (state == ST_LOCKED) && (bit_cnt == BIT_CNT_LAST);
  // The final bit's error is folded in here so the reported total covers
  // the whole window even though the accumulator is cleared on that edge.
  assign window_total = err_acc + {{WINDOW_LOG2{1'b0}}, bit_err};
  assign window_loss  = window_end && (window_total > LOSS_LIM);

  // Synchroniser next-state: seed, confirm alignment, then track.
  always_comb begin
    state_next = state;
    case (state)
      ST_SEARCH: begin
        if ((fill_cnt == FILL_LAST) && load_nonzero) begin
          state_next = ST_VERIFY;
        end else begin
          state_next = ST_SEARCH;
        end
      end
      ST_VERIFY: begin
        if (bit_err) begin
          state_next = ST_SEARCH;
        end else if (verify_cnt == VERIFY_LAST) begin
          state_next = ST_LOCKED;
        end else begin
          state_next = ST_VERIFY;
        end
      end
      ST_LOCKED: begin
        if (window_loss) begin
          state_next = ST_SEARCH;
        end else begin
          state_next = ST_LOCKED;
        end
      end
      default: begin
        state_next = ST_SEARCH;
      end
    endcase
  end

  // State register and the lock flag, which moves on the same edge as state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_SEARCH;
      locked <= 1'b0;
    end else if (sam_clk_en) begin
      state  <= state_next;
      locked <= (state_next == ST_LOCKED);
    end else begin
      state  <= state;
      locked <= locked;
    end
  end

  // Count bits loaded while seeding; an all-zero seed restarts the fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt <= 4'd0;
    end else if (sam_clk_en) begin
      if (state != ST_SEARCH) begin
        fill_cnt <= 4'd0;
      end else if (fill_cnt == FILL_LAST) begin
        fill_cnt <= 4'd0;
      end else begin
        fill_cnt <= fill_cnt + 4'd1;
      end
    end else begin
      fill_cnt <= fill_cnt;
    end
  end

  // Run length of consecutive clean bits while verifying alignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      verify_cnt <= VCW'(0);
    end else if (sam_clk_en) begin
      if ((state != ST_VERIFY) || bit_err || (verify_cnt == VERIFY_LAST)) begin
        verify_cnt <= VCW'(0);
      end else begin
        verify_cnt <= verify_cnt + VCW'(1);
      end
    end else begin
      verify_cnt <= verify_cnt;
    end
  end

  // Window bit counter and error accumulator; idle at zero when not locked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= {WINDOW_LOG2{1'b0}};
      err_acc <= {ACC_W{1'b0}};
    end else if (sam_clk_en) begin
      if ((state != ST_LOCKED) || window_end) begin
        bit_cnt <= {WINDOW_LOG2{1'b0}};
        err_acc <= {ACC_W{1'b0}};
      end else begin
        bit_cnt <= bit_cnt + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
        err_acc <= window_total;
      end
    end else begin
      bit_cnt <= bit_cnt;
      err_acc <= err_acc;
    end
  end

  // Publish the completed window total; held until the next window ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= {ACC_W{1'b0}};
    end else if (sam_clk_en && window_end) begin
      err_count <= window_total;
    end else begin
      err_count <= err_count;
    end
  end

  // Single-clock strobe marking an err_count update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_done <= 1'b0;
    end else begin
      window_done <= sam_clk_en && window_end;
    end
  end

  // Count lock losses, sticking at the top value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resync_count <= 8'd0;
    end else if (sam_clk_en && window_loss && (resync_count != RESYNC_MAX)) begin
      resync_count <= resync_count + 8'd1;
    end else begin
      resync_count <= resync_count;
    end
  end

endmodule

// File: tb/tb_ber_counter.sv
// Self-checking bench for ber_counter. A small window keeps run time short.
// The reference PRBS is produced from the recurrence b[n] = b[n-14]^b[n-15];
// expected error totals come from comparing driven bits with that stream.
module tb_ber_counter;

  localparam int WL       = 8;
  localparam int VL       = 32;
  localparam int LT       = 32;
  localparam int WIN      = 1 << WL;
  localparam int LOCK_LAT = 15 + VL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sam_clk_en = 1'b0;
  logic          bit_in = 1'b0;
  logic          locked;
  logic [WL:0]   err_count;
  logic          window_done;
  logic [7:0]    resync_count;

  int   vectors = 0;
  int   miscompares = 0;
  int   exp_resync = 0;
  logic last_wd;

  bit pending[$];
  bit hist[$];

  ber_counter #(
    .WINDOW_LOG2 (WL),
    .VERIFY_LEN  (VL),
    .LOSS_THRESH (LT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sam_clk_en   (sam_clk_en),
    .bit_in       (bit_in),
    .locked       (locked),
    .err_count    (err_count),
    .window_done  (window_done),
    .resync_count (resync_count)
  );

  always #5 clk = ~clk;

  // Start a fresh PRBS stream from a random nonzero 15-bit seed.
  function automatic void prbs_seed();
    int unsigned seed;
    seed = $urandom_range(32767, 1);
    pending.delete();
    hist.delete();
    for (int i = 0; i < 15; i++) pending.push_back(seed[i]);
  endfunction

  // Next true bit of the stream.
  function automatic bit prbs_next();
    bit b;
    if (pending.size() > 0) b = pending.pop_front();
    else b = hist[0] ^ hist[1];
    hist.push_back(b);
    if (hist.size() > 15) void'(hist.pop_front());
    return b;
  endfunction

  // One enabled bit, then three idle clocks; window_done must be one clk wide.
  task automatic send_bit(input logic b);
    bit wide = 1'b0;
    bit_in = b;
    sam_clk_en = 1'b1;
    @(negedge clk);
    sam_clk_en = 1'b0;
    last_wd = window_done;
    repeat (3) begin
      @(negedge clk);
      if (window_done !== 1'b0) wide = 1'b1;
    end
    vectors++;
    if (wide) begin
      miscompares++;
      $display("FAIL wd_width: window_done high %0d, required 0 on idle clocks", wide);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sam_clk_en = 1'b0;
    bit_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_resync = 0;
  endtask

  // Continue the current stream until lock; lock must land exactly on time.
  task automatic count_to_lock(input string name);
    int lock_at = 0;
    for (int n = 1; n <= 4 * LOCK_LAT && lock_at == 0; n++) begin
      send_bit(prbs_next());
      if (locked === 1'b1) lock_at = n;
    end
    vectors++;
    if (lock_at != LOCK_LAT) begin
      miscompares++;
      $display("FAIL %s lock_latency: got %0d enables, required %0d", name, lock_at, LOCK_LAT);
    end
  endtask

  task automatic acquire(input string name);
    prbs_seed();
    count_to_lock(name);
  endtask

  // One full window after lock: n_flips distinct corrupted bits, or random data.
  task automatic run_window(input int n_flips, input bit random_data, output int exp_errs);
    bit   flip [WIN];
    int   placed = 0;
    int   pos;
    logic b;
    logic e;
    for (int i = 0; i < WIN; i++) flip[i] = 1'b0;
    while (placed < n_flips) begin
      pos = $urandom_range(WIN - 1, 0);
      if (!flip[pos]) begin
        flip[pos] = 1'b1;
        placed++;
      end
    end
    exp_errs = 0;
    for (int k = 0; k < WIN; k++) begin
      e = prbs_next();
      if (random_data) b = 1'($urandom_range(1, 0));
      else b = e ^ flip[k];
      if (b != e) exp_errs++;
      send_bit(b);
      vectors++;
      if (k != WIN - 1 && last_wd !== 1'b0) begin
        miscompares++;
        $display("FAIL early_window_done: at bit %0d got %b, required 0", k, last_wd);
      end else if (k == WIN - 1 && last_wd !== 1'b1) begin
        miscompares++;
        $display("FAIL window_done: at last bit got %b, required 1", last_wd);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (locked !== 1'b0 || err_count !== '0 || window_done !== 1'b0 || resync_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_values: got locked=%b err=%0d wd=%b resync=%0d, required 0/0/0/0",
               locked, err_count, window_done, resync_count);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (locked !== 1'b0 || err_count !== '0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got locked=%b err=%0d, required 0/0", locked, err_count);
    end
  endtask

  task automatic test_lock_clean();
    int e;
    do_reset();
    acquire("lock_clean");
    run_window(0, 1'b0, e);
    vectors++;
    if (err_count !== (WL+1)'(e) || locked !== 1'b1 || resync_count !== 8'd0) begin
      miscompares++;
      $display("FAIL clean_window: got err=%0d locked=%b resync=%0d, required %0d/1/0",
               err_count, locked, resync_count, e);
    end
  endtask

  task automatic test_window_errors();
    int flips [4];
    int e;
    flips[0] = 1;
    flips[1] = 1;
    flips[2] = LT;
    flips[3] = $urandom_range(LT - 1, 2);
    for (int w = 0; w < 4; w++) begin
      run_window(flips[w], 1'b0, e);
      vectors++;
      if (err_count !== (WL+1)'(e) || locked !== 1'b1) begin
        miscompares++;
        $display("FAIL window_errors[%0d]: got err=%0d locked=%b, required %0d/1",
                 w, err_count, locked, e);
      end
    end
  endtask

  task automatic test_random_loss();
    int e;
    run_window(0, 1'b1, e);
    if (e > LT) exp_resync++;
    vectors++;
    if (err_count !== (WL+1)'(e) || locked !== (e <= LT) || resync_count !== 8'(exp_resync)) begin
      miscompares++;
      $display("FAIL random_loss: got err=%0d locked=%b resync=%0d, required %0d/%b/%0d",
               err_count, locked, resync_count, e, (e <= LT), exp_resync);
    end
  endtask

  task automatic test_threshold();
    int e;
    acquire("thresh_relock");
    run_window(LT + 1, 1'b0, e);
    exp_resync++;
    vectors++;
    if (err_count !== (WL+1)'(e) || locked !== 1'b0 || resync_count !== 8'(exp_resync)) begin
      miscompares++;
      $display("FAIL threshold_loss: got err=%0d locked=%b resync=%0d, required %0d/0/%0d",
               err_count, locked, resync_count, e, exp_resync);
    end
  endtask

  task automatic test_reset_mid_window();
    int   part;
    int   e;
    bit   saw_wd = 1'b0;
    logic b;
    acquire("midwin_lock");
    part = $urandom_range(200, 50);
    for (int k = 0; k < part; k++) begin
      b = prbs_next();
      if (k % 37 == 5) b = ~b;
      send_bit(b);
      if (last_wd !== 1'b0) saw_wd = 1'b1;
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    vectors++;
    if (saw_wd || locked !== 1'b0 || err_count !== '0 || window_done !== 1'b0 || resync_count !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset: got partial_wd=%b locked=%b err=%0d wd=%b resync=%0d, required 0/0/0/0/0",
               saw_wd, locked, err_count, window_done, resync_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_resync = 0;
    count_to_lock("midwin_relock");
    run_window(0, 1'b0, e);
    vectors++;
    if (err_count !== '0 || locked !== 1'b1 || resync_count !== 8'd0) begin
      miscompares++;
      $display("FAIL after_reset_window: got err=%0d locked=%b resync=%0d, required 0/1/0",
               err_count, locked, resync_count);
    end
  endtask

  task automatic test_verify_error();
    int pos [3];
    pos[0] = 10;
    pos[1] = VL - 1;
    pos[2] = $urandom_range(VL - 2, 0);
    for (int p = 0; p < 3; p++) begin
      do_reset();
      prbs_seed();
      for (int k = 0; k < 15 + pos[p]; k++) send_bit(prbs_next());
      send_bit(~prbs_next());
      vectors++;
      if (locked !== 1'b0) begin
        miscompares++;
        $display("FAIL verify_err[%0d]: locked got %b, required 0", pos[p], locked);
      end
      count_to_lock("verify_relock");
    end
  endtask

  task automatic test_all_zero();
    bit bad = 1'b0;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      send_bit(1'b0);
      if (locked !== 1'b0 || last_wd !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL all_zero: locked or window_done got 1, required 0");
    end
  endtask

  initial begin
    test_reset();
    test_lock_clean();
    test_window_errors();
    test_random_loss();
    test_threshold();
    test_reset_mid_window();
    test_verify_error();
    test_all_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
